// File: rtl/luz_pkg.sv
// Shared constants for the light-control link, used by both the host-command
// decoder and the duty read-back encoder so the two directions always agree.
// Holds the duty grid, the ASCII codes and the read-back transmitter state enum.
package luz_pkg;

  // Command letters 'a'..'x' map onto duty = DUTY_STEP * k, k = 0..LETTER_COUNT-1.
  localparam int DUTY_STEP    = 2000;
  localparam int LETTER_COUNT = 24;
  // 'y' is off-grid: full brightness is 50000, not 48000.
  localparam int DUTY_Y       = 50000;

  localparam logic [7:0] ASCII_A   = 8'd97;
  localparam logic [7:0] ASCII_Y   = 8'd121;
  localparam logic [7:0] ASCII_UNK = 8'd63;
  localparam logic [7:0] ASCII_LF  = 8'd10;

  typedef enum logic [2:0] {
    IDLE,
    ENCODE,
    START,
    DATA,
    STOP,
    NEXT
  } luz_state_t;

endpackage

// File: rtl/duty_to_ascii.sv
// Purpose: maps a 16-bit PWM duty value to the command letter that produces it.
// Latency: purely combinational. Backpressure: none.
// Ports: dutty (duty value in), code (ASCII letter out; '?' for any value
//        that no command letter produces).
module duty_to_ascii
  import luz_pkg::*;
(
  input  logic [15:0] dutty,
  output logic [7:0]  code
);

  // Exact-match comparator bank. Only exact grid points map to a letter, so a
  // duty set by some other path (e.g. 48000 or 1999) reads back as '?'.
  always_comb begin
    code = ASCII_UNK;
    if (dutty == 16'(DUTY_Y)) begin
      code = ASCII_Y;
    end else begin
      for (int k = 0; k < LETTER_COUNT; k++) begin
        if (dutty == 16'(DUTY_STEP * k)) begin
          code = ASCII_A + 8'(k);
        end
      end
    end
  end

endmodule

// File: rtl/reporte_luz_tx.sv
// Purpose: reports the current PWM duty to the host as its command letter over
//          UART 8N1, optionally followed by LF.
// Latency: start bit begins 2 cycles after an accepted init; each byte takes
//          10*BAUD_DIV cycles; done pulses once after the last stop bit.
// Backpressure: none; init is taken only in IDLE and never while busy or in the
//               done cycle, and is dropped otherwise (no queueing).
// Ports: clk, rst (sync, active-high), init (start strobe), dutty (duty to
//        report, captured on accepted init), tx (serial line, idle high),
//        busy (frame in progress), done (one-cycle end-of-report pulse).
// BAUD_DIV must be at least 2.
module reporte_luz_tx
  import luz_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter bit SEND_LF  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [15:0] dutty,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int              CW      = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(BAUD_DIV - 1);

  luz_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic [15:0]   duty_q, duty_n;
  logic          letter, letter_n;   // byte in flight is the letter (not LF)
  logic          tx_n, done_n;
  logic [7:0]    code;

  duty_to_ascii u_enc (
    .dutty (duty_q),
    .code  (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      duty_q  <= '0;
      letter  <= 1'b0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      duty_q  <= duty_n;
      letter  <= letter_n;
      tx      <= tx_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    duty_n   = duty_q;
    letter_n = letter;
    done_n   = 1'b0;
    tx_n     = 1'b1;

    case (state)
      IDLE: begin
        // done is high in the first IDLE cycle; an init there is ignored.
        if (init && !done) begin
          duty_n  = dutty;
          state_n = ENCODE;
        end
      end
      ENCODE: begin
        shift_n  = code;
        bit_n    = '0;
        letter_n = 1'b1;
        cnt_n    = '0;
        state_n  = START;
      end
      START: begin
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = shift >> 1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (letter && SEND_LF) begin
            state_n = NEXT;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      NEXT: begin
        shift_n  = ASCII_LF;
        bit_n    = '0;
        letter_n = 1'b0;
        cnt_n    = '0;
        state_n  = START;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // tx is registered from the next-state view so the pin never glitches.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reporte_luz_tx.sv
module tb_reporte_luz_tx;

  localparam int B = 4;

  logic        clk;
  logic        rst;
  logic        init;
  logic [15:0] dutty;
  logic        tx0, busy0, done0;
  logic        tx1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  logic tx0_h   [0:127];
  logic busy0_h [0:127];
  logic done0_h [0:127];
  logic tx1_h   [0:127];
  logic busy1_h [0:127];
  logic done1_h [0:127];

  reporte_luz_tx #(.BAUD_DIV(B), .SEND_LF(1'b0)) dut0 (
    .clk(clk), .rst(rst), .init(init), .dutty(dutty),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  reporte_luz_tx #(.BAUD_DIV(B), .SEND_LF(1'b1)) dut1 (
    .clk(clk), .rst(rst), .init(init), .dutty(dutty),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive after posedge and sample 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    init  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Records cycles 0..n-1 where cycle 0 is the cycle init is asserted.
  // Optional extra rst / init pulses (with a new dutty) at given cycles.
  task automatic capture(input logic [15:0] d, input int n, input int rst_at,
                         input int init2_at, input logic [15:0] d2);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      init = (i == 0) || (i == init2_at);
      rst  = (i == rst_at);
      if (i == 0) dutty = d;
      else if (i == init2_at) dutty = d2;
      tx0_h[i] = tx0; busy0_h[i] = busy0; done0_h[i] = done0;
      tx1_h[i] = tx1; busy1_h[i] = busy1; done1_h[i] = done1;
    end
    init = 1'b0;
    rst  = 1'b0;
  endtask

  function automatic logic [7:0] dec(input logic sel, input int s);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) begin
      b[j] = sel ? tx1_h[s + B * (1 + j) + B / 2] : tx0_h[s + B * (1 + j) + B / 2];
    end
    return b;
  endfunction

  // Start bit low for its whole length and stop bit high for its whole length.
  function automatic logic frame_ok(input logic sel, input int s);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < B; i++) begin
      if ((sel ? tx1_h[s + i] : tx0_h[s + i]) !== 1'b0) ok = 1'b0;
      if ((sel ? tx1_h[s + 9 * B + i] : tx0_h[s + 9 * B + i]) !== 1'b1) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int count_done(input logic sel, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) begin
      if ((sel ? done1_h[i] : done0_h[i]) === 1'b1) c++;
    end
    return c;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    init  = 1'b1;
    dutty = 16'd0;
    step();
    step();
    checks++; if (tx0 !== 1'b1)   begin failures++; $display("FAIL reset_tx0 got=%b exp=1", tx0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done0 got=%b exp=0", done0); end
    checks++; if (tx1 !== 1'b1)   begin failures++; $display("FAIL reset_tx1 got=%b exp=1", tx1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    rst  = 1'b0;
    init = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic ok;
    do_reset();
    capture(16'd0, 50, -1, -1, 16'd0);
    checks++; if (tx0_h[1] !== 1'b1) begin failures++; $display("FAIL basic_tx_c1 got=%b exp=1", tx0_h[1]); end
    checks++; if (tx0_h[2] !== 1'b0) begin failures++; $display("FAIL basic_start_c2 got=%b exp=0", tx0_h[2]); end
    checks++; if (!frame_ok(1'b0, 2)) begin failures++; $display("FAIL basic_framing got=bad exp=good"); end
    checks++; if (dec(1'b0, 2) !== 8'h61) begin failures++; $display("FAIL basic_byte got=%h exp=61", dec(1'b0, 2)); end
    ok = (busy0_h[0] === 1'b0) && (busy0_h[42] === 1'b0);
    for (int i = 1; i <= 41; i++) if (busy0_h[i] !== 1'b1) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL basic_busy_window got=bad exp=high_1_to_41"); end
    checks++; if (done0_h[42] !== 1'b1) begin failures++; $display("FAIL basic_done_c42 got=%b exp=1", done0_h[42]); end
    checks++; if (count_done(1'b0, 0, 49) !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", count_done(1'b0, 0, 49)); end
  endtask

  task automatic test_encode();
    logic [15:0] d_tab [0:3];
    logic [7:0]  e_tab [0:3];
    d_tab[0] = 16'd46000; e_tab[0] = 8'h78;
    d_tab[1] = 16'd50000; e_tab[1] = 8'h79;
    d_tab[2] = 16'd48000; e_tab[2] = 8'h3F;
    d_tab[3] = 16'd1999;  e_tab[3] = 8'h3F;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      capture(d_tab[t], 45, -1, -1, 16'd0);
      checks++;
      if (dec(1'b0, 2) !== e_tab[t])
        begin failures++; $display("FAIL encode_%0d got=%h exp=%h", d_tab[t], dec(1'b0, 2), e_tab[t]); end
    end
  endtask

  task automatic test_lf();
    logic ok;
    do_reset();
    capture(16'd20000, 90, -1, -1, 16'd0);
    checks++; if (dec(1'b1, 2) !== 8'h6B) begin failures++; $display("FAIL lf_letter got=%h exp=6b", dec(1'b1, 2)); end
    checks++; if (tx1_h[42] !== 1'b1) begin failures++; $display("FAIL lf_gap_c42 got=%b exp=1", tx1_h[42]); end
    checks++; if (!frame_ok(1'b1, 43)) begin failures++; $display("FAIL lf_framing got=bad exp=good"); end
    checks++; if (dec(1'b1, 43) !== 8'h0A) begin failures++; $display("FAIL lf_byte got=%h exp=0a", dec(1'b1, 43)); end
    checks++; if (done1_h[83] !== 1'b1) begin failures++; $display("FAIL lf_done_c83 got=%b exp=1", done1_h[83]); end
    checks++; if (count_done(1'b1, 0, 89) !== 1) begin failures++; $display("FAIL lf_done_count got=%0d exp=1", count_done(1'b1, 0, 89)); end
    ok = 1'b1;
    for (int i = 1; i <= 82; i++) if (busy1_h[i] !== 1'b1) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL lf_busy_window got=bad exp=high_1_to_82"); end
    checks++; if (dec(1'b0, 2) !== 8'h6B) begin failures++; $display("FAIL nolf_letter got=%h exp=6b", dec(1'b0, 2)); end
  endtask

  task automatic test_ignore_init();
    logic ok;
    do_reset();
    capture(16'd0, 60, -1, 10, 16'd46000);
    checks++; if (dec(1'b0, 2) !== 8'h61) begin failures++; $display("FAIL busy_init_byte got=%h exp=61", dec(1'b0, 2)); end
    checks++; if (count_done(1'b0, 0, 59) !== 1) begin failures++; $display("FAIL busy_init_done_count got=%0d exp=1", count_done(1'b0, 0, 59)); end
    ok = 1'b1;
    for (int i = 43; i < 60; i++) if (tx0_h[i] !== 1'b1 || busy0_h[i] !== 1'b0) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL busy_init_no_second got=activity exp=idle"); end
  endtask

  task automatic test_rst_midframe();
    do_reset();
    capture(16'd2000, 70, 15, 20, 16'd2000);
    checks++; if (tx0_h[16] !== 1'b1) begin failures++; $display("FAIL rst_tx_c16 got=%b exp=1", tx0_h[16]); end
    checks++; if (busy0_h[16] !== 1'b0) begin failures++; $display("FAIL rst_busy_c16 got=%b exp=0", busy0_h[16]); end
    checks++; if (count_done(1'b0, 0, 61) !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", count_done(1'b0, 0, 61)); end
    checks++; if (tx0_h[21] !== 1'b1 || tx0_h[22] !== 1'b0)
      begin failures++; $display("FAIL rst_restart_edge got=%b%b exp=10", tx0_h[21], tx0_h[22]); end
    checks++; if (dec(1'b0, 22) !== 8'h62) begin failures++; $display("FAIL rst_restart_byte got=%h exp=62", dec(1'b0, 22)); end
    checks++; if (done0_h[62] !== 1'b1) begin failures++; $display("FAIL rst_restart_done got=%b exp=1", done0_h[62]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [7:0]  e;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      d = (k < 24) ? 16'(2000 * k) : 16'd50000;
      e = 8'(97 + k);
      // 44 cycles: the next capture asserts init in cycle 43, right after done.
      capture(d, 44, -1, -1, 16'd0);
      checks++;
      if (dec(1'b0, 2) !== e || done0_h[42] !== 1'b1)
        begin failures++; $display("FAIL sweep_%0d got=%h done=%b exp=%h", k, dec(1'b0, 2), done0_h[42], e); end
    end
  endtask

  initial begin
    rst   = 1'b1;
    init  = 1'b0;
    dutty = 16'd0;
    test_reset();
    test_basic();
    test_encode();
    test_lf();
    test_ignore_init();
    test_rst_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reporte_luz_tx.md
# reporte_luz_tx

Reverse path of the light-control link. Takes the current 16-bit PWM duty value, encodes it back to the single ASCII command letter ('a'..'y') that produces that duty, and serializes the letter over UART (8N1) to the host. An optional trailing LF can follow the letter. It sits beside the duty-control register and drives the board's UART TX pin, so the host can read back the light level.

## Interface
- BAUD_DIV, 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- SEND_LF, 1: when 1, append byte 8'd10 after the letter.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- init  in  1  one-cycle start strobe; sampled only in IDLE.
- dutty  in  16  duty value to report; captured on the accepted init.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high from the cycle after an accepted init until frame end.
- done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Encoding, exact match only:
  - dutty = 2000·k for k = 0..23 → 8'd97 + k ('a'..'x'; 46000 → 'x').
  - dutty = 50000 → 8'd121 ('y').
  - Any other value, including 48000 → 8'd63 ('?').
- FSM states: IDLE, ENCODE, START, DATA, STOP, NEXT.
- IDLE: tx=1, busy=0. init=1 → capture dutty, go to ENCODE.
- ENCODE: register the encoded byte into the shift register, bit index = 0 → START.
- START: tx=0 for BAUD_DIV cycles → DATA.
- DATA: tx = shift[0], LSB first; each bit lasts BAUD_DIV cycles; after bit 7 → STOP.
- STOP: tx=1 for BAUD_DIV cycles. Then:
  - If a letter was just sent and SEND_LF=1 → NEXT.
  - Otherwise done=1 for one cycle, busy=0 → IDLE.
- NEXT: load 8'd10, bit index = 0 → START. busy stays high; done does not pulse between bytes.
- init while busy is ignored; there is no queueing.
- A dutty change after capture does not affect the frame in flight.
- Baud counter: counts 0..BAUD_DIV-1 and wraps; its width is $clog2(BAUD_DIV). The counter resets to 0 on every state entry.

## Timing
- Reset values: tx=1, busy=0, done=0, state=IDLE, baud counter=0, shift register=0.
- An rst asserted mid-frame aborts the frame. The next cycle shows tx=1, busy=0, and no done pulse.
- init accepted at cycle 0 → ENCODE at cycle 1 (busy=1) → start bit begins at cycle 2.
- Start-bit falling edge follows init by exactly 2 cycles.
- One byte occupies 10·BAUD_DIV cycles (start + 8 data + stop).
- SEND_LF=0: done is high at cycle 2 + 10·BAUD_DIV; busy is low the same cycle.
- SEND_LF=1: the LF start bit begins 1 cycle after the letter's stop bit (the NEXT state). done is high at cycle 3 + 20·BAUD_DIV.
- init asserted in the same cycle done is high is ignored. The earliest accepted init is the cycle after done.
- rst and init high together: rst wins.

## Structure
- Shared package luz_pkg holds:
  - DUTY_STEP = 2000, DUTY_Y = 50000.
  - ASCII_A = 8'd97, ASCII_Y = 8'd121, ASCII_UNK = 8'd63, ASCII_LF = 8'd10.
  - The FSM state enum.
- The control-side decoder uses the same package constants, so the two directions stay consistent.
- One sub-module: duty_to_ascii, purely combinational (16-bit in, 8-bit out), instantiated ahead of the ENCODE register.
- The UART shift and baud logic stays in the top module.

## Test plan
- BAUD_DIV=4, SEND_LF=0, dutty=0, init pulse:
  - Start bit at cycle 2.
  - tx bits decode to 8'h61 ('a').
  - done at cycle 42; busy high for cycles 1..41.
- dutty=46000 → 8'h78 ('x'); dutty=50000 → 8'h79 ('y'); dutty=48000 and dutty=1999 → 8'h3F ('?').
- SEND_LF=1, dutty=20000:
  - Frames 8'h6B then 8'h0A.
  - Single done at cycle 83; no done between the two bytes.
- init pulsed at cycle 10 while busy, and dutty changed mid-frame: the output frame is unchanged and no second frame follows.
- rst asserted at cycle 15 mid-data: tx=1 and busy=0 at cycle 16, no done. A new init at cycle 20 produces a clean frame starting at cycle 22.
- Sweep all 25 letter duties back-to-back, each init issued the cycle after done: every decoded byte matches 'a'..'y' in order.
